// File: rtl/mdu_sequencer.sv
// Multiply/divide unit sequencer: owns HI/LO, times multi-cycle ops and stalls HI/LO accesses while busy.
// Optional multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU) are enabled by defining MDU_MACC_EN.
module mdu_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [3:0]  mul_op,
    input  logic [1:0]  mthilo,
    input  logic [1:0]  mfhilo,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hilo_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

`ifdef MDU_MACC_EN
    localparam logic MACC_EN = 1'b1;
`else
    localparam logic MACC_EN = 1'b0;
`endif

    localparam logic IDLE = 1'b0;
    localparam logic RUN  = 1'b1;

    logic        state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [2:0]  op_reg;
    logic [31:0] a_reg, b_reg;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;

    logic        is_mdu_op, is_mt, is_mf, access, start, mt_we;
    logic [63:0] a_ext, b_ext, prod, acc;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

    // Accumulate ops only count as MDU ops when the feature is built in.
    assign is_mdu_op = (mul_op <= 4'd3) || (MACC_EN && (mul_op <= 4'd7));
    assign is_mt     = ~mthilo[1];
    assign is_mf     = mfhilo[0] ^ mfhilo[1];
    assign access    = op_valid & (is_mdu_op | is_mt | is_mf);

    assign busy  = (state_reg == RUN);
    assign stall = busy & access;
    assign start = op_valid & is_mdu_op & (state_reg == IDLE);
    assign mt_we = op_valid & is_mt & ~stall;

    // Bit 0 of the opcode selects signed arithmetic for every operation.
    assign a_ext = op_reg[0] ? {{32{a_reg[31]}}, a_reg} : {32'd0, a_reg};
    assign b_ext = op_reg[0] ? {{32{b_reg[31]}}, b_reg} : {32'd0, b_reg};
    assign prod  = a_ext * b_ext;
    assign acc   = {hi_reg, lo_reg};

    // Signed divide via magnitudes; 0x80000000 / -1 wraps to 0x80000000 remainder 0.
    assign a_neg = op_reg[0] & a_reg[31];
    assign b_neg = op_reg[0] & b_reg[31];
    assign a_mag = a_neg ? (32'd0 - a_reg) : a_reg;
    assign b_mag = b_neg ? (32'd0 - b_reg) : b_reg;
    assign q_mag = (b_mag != 32'd0) ? (a_mag / b_mag) : 32'd0;
    assign r_mag = (b_mag != 32'd0) ? (a_mag % b_mag) : 32'd0;
    assign quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem   = a_neg ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        if (state_reg == IDLE) begin
            if (start) begin
                state_next = RUN;
                cnt_next   = (mul_op[3:1] == 3'b001) ? 4'd10 : 4'd5;
            end
        end else begin
            cnt_next = cnt_reg - 4'd1;
            if (cnt_reg == 4'd1) begin
                state_next = IDLE;
                cnt_next   = 4'd0;
                case (op_reg[2:1])
                    2'b00: {hi_next, lo_next} = prod;
                    2'b01: begin
                        if (b_reg != 32'd0) begin
                            hi_next = rem;
                            lo_next = quot;
                        end
                    end
                    2'b10:   {hi_next, lo_next} = acc + prod;
                    default: {hi_next, lo_next} = acc - prod;
                endcase
            end
        end
        if (mt_we) begin
            if (mthilo[0]) begin
                hi_next = rs_val;
            end else begin
                lo_next = rs_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            op_reg    <= 3'd0;
            a_reg     <= 32'd0;
            b_reg     <= 32'd0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            if (start) begin
                op_reg <= mul_op[2:0];
                a_reg  <= rs_val;
                b_reg  <= rt_val;
            end
        end
    end

    assign hi       = hi_reg;
    assign lo       = lo_reg;
    assign hilo_out = (mfhilo == 2'b10) ? hi_reg :
                      (mfhilo == 2'b01) ? lo_reg : 32'd0;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: hand-computed HI/LO results, busy/stall timing and reset behaviour.
// Covers both builds; the accumulate case switches on MDU_MACC_EN.
module tb_mdu_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic [3:0]  mul_op;
    logic [1:0]  mthilo;
    logic [1:0]  mfhilo;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        stall;
    logic [31:0] hilo_out;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    int n;

    mdu_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_valid (op_valid),
        .mul_op   (mul_op),
        .mthilo   (mthilo),
        .mfhilo   (mfhilo),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .busy     (busy),
        .stall    (stall),
        .hilo_out (hilo_out),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
            $display("check %s: %h ok", tag, observed);
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic idle_inputs;
        op_valid = 1'b0;
        mul_op   = 4'd8;
        mthilo   = 2'b10;
        mfhilo   = 2'b00;
    endtask

    // Present one MDU op for a single cycle and confirm it was accepted.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1;
        mul_op   = op;
        rs_val   = a;
        rt_val   = b;
        tick();
        idle_inputs();
        #1;
        check("start_busy", {31'd0, busy}, 32'd1);
    endtask

    // Returns the number of edges until busy drops (bounded).
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        rs_val = 32'd0;
        rt_val = 32'd0;
        idle_inputs();
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_hilo_out", hilo_out, 32'd0);
        rst_n = 1'b1;

        // MULT -2 * 3, accepted on the first edge after reset release
        issue(4'd1, 32'hFFFF_FFFE, 32'd3);
        check("mult_no_stall", {31'd0, stall}, 32'd0);
        wait_idle(n);
        check("mult_cycles", n, 32'd5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        // DIV -7 / 2
        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        check("div_cycles", n, 32'd10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        // DIVU by zero leaves HI/LO alone but still takes 10 cycles
        issue(4'd2, 32'd5, 32'd0);
        wait_idle(n);
        check("divu0_cycles", n, 32'd10);
        check("divu0_lo", lo, 32'hFFFF_FFFD);
        check("divu0_hi", hi, 32'hFFFF_FFFF);

        // DIV overflow case
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        check("divovf_lo", lo, 32'h8000_0000);
        check("divovf_hi", hi, 32'd0);

        // DIVU 100 / 7
        issue(4'd2, 32'd100, 32'd7);
        wait_idle(n);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        // MULTU 3*4; MFLO arrives one cycle into the multiply and waits 4 cycles
        issue(4'd0, 32'd3, 32'd4);
        tick();
        op_valid = 1'b1;
        mfhilo   = 2'b01;
        #1;
        n = 0;
        while (stall && n < 40) begin
            tick();
            n++;
        end
        check("mflo_stall_cycles", n, 32'd4);
        check("mflo_stall_low", {31'd0, stall}, 32'd0);
        check("mflo_data", hilo_out, 32'd12);
        idle_inputs();

        // MTHI while busy: held until the multiply commits, written one edge later
        issue(4'd0, 32'h0001_0000, 32'h0001_0000);
        op_valid = 1'b1;
        mthilo   = 2'b01;
        rs_val   = 32'h0000_1234;
        #1;
        check("mthi_stall", {31'd0, stall}, 32'd1);
        n = 0;
        while (stall && n < 40) begin
            check("mthi_held", hi, 32'd0);
            tick();
            n++;
        end
        check("mthi_stall_cycles", n, 32'd5);
        check("mthi_mult_hi", hi, 32'd1);
        check("mthi_mult_lo", lo, 32'd0);
        tick();
        check("mthi_written", hi, 32'h0000_1234);
        idle_inputs();

        // Prime HI=0, LO=0xFFFFFFFF with MTHI/MTLO
        op_valid = 1'b1;
        mthilo   = 2'b01;
        rs_val   = 32'd0;
        tick();
        mthilo   = 2'b00;
        rs_val   = 32'hFFFF_FFFF;
        tick();
        idle_inputs();
        check("mt_hi", hi, 32'd0);
        check("mt_lo", lo, 32'hFFFF_FFFF);

`ifdef MDU_MACC_EN
        issue(4'd4, 32'd1, 32'd1);
        wait_idle(n);
        check("maddu_cycles", n, 32'd5);
        check("maddu_hi", hi, 32'd1);
        check("maddu_lo", lo, 32'd0);
`else
        op_valid = 1'b1;
        mul_op   = 4'd4;
        rs_val   = 32'd1;
        rt_val   = 32'd1;
        #1;
        check("maddu_off_stall", {31'd0, stall}, 32'd0);
        tick();
        idle_inputs();
        check("maddu_off_busy", {31'd0, busy}, 32'd0);
        tick();
        check("maddu_off_hi", hi, 32'd0);
        check("maddu_off_lo", lo, 32'hFFFF_FFFF);
`endif

        // Reset during cycle 3 of a DIV discards it immediately
        issue(4'd3, 32'd100, 32'd3);
        tick();
        tick();
        op_valid = 1'b1;
        mfhilo   = 2'b10;
        rst_n    = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_stall", {31'd0, stall}, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        check("midrst_hilo_out", hilo_out, 32'd0);
        idle_inputs();
        tick();
        rst_n = 1'b1;
        issue(4'd0, 32'd2, 32'd2);
        wait_idle(n);
        check("post_rst_cycles", n, 32'd5);
        check("post_rst_lo", lo, 32'd4);
        check("post_rst_hi", hi, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
